avalon_multi_timer: RTL and testbench
=====================================

# avalon_multi_timer

Parametrised, multi-channel successor to the single interval timer on the Nios II Avalon-MM bus. It provides NUM_CH independent down-counters, each with its own period, an 8-bit clock prescaler, one-shot or continuous mode, a snapshot register and a per-channel interrupt. The block sits on the system interconnect as a single slave with one combined `irq` line to the CPU. A global pending register allows multiple timeouts to be serviced and cleared in one access.

## Interface
- NUM_CH, 2: channel count, 1..7.
- CNT_W, 32: counter/period width, 16..32; the register field is zero-extended to 32 bits on read.
- RESET_PERIOD, 49999: reset value of every period and counter, in prescaled ticks minus 1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- address  in  5  word address: channel c occupies words 4c..4c+3; word 31 is global.
- writedata  in  32  write data.
- readdata  out  32  registered read data; read latency 1.
- irq  out  1  OR of all irq_vec bits.
- irq_vec  out  NUM_CH  per-channel interrupt: TO[c] & ITO[c].

## Operation
- **Channel registers (offsets from 4c):**
  - +0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - +1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bits15:8 PRE (read/write). bit2 START and bit3 STOP are write-only strobes and read 0.
  - +2 PERIOD: CNT_W bits.
  - +3 SNAP: read returns the captured count; any write captures the live count.
- **Global register (word 31):**
  - Read returns the TO bits of all channels in bits NUM_CH-1:0.
  - A write clears TO[c] for each writedata[c]=1 (W1C).
- **Unmapped addresses** (channels ≥ NUM_CH, words 28..30): read 0; writes ignored.
- **Prescaler:** per-channel counter p.
  - tick = RUN & (p == PRE). On tick p wraps to 0; otherwise p increments while RUN.
  - PRE=0 gives a tick every cycle.
- **Counting:** on tick, count <= (count == 0) ? PERIOD : count - 1.
- **Start/stop:**
  - START sets RUN. STOP clears RUN. If both are written together, START wins.
  - The count and p are preserved across stop/start.
- **One-shot (CONT=0):** RUN is cleared on the first tick where count==0. The count reloads to PERIOD and holds.
- **Continuous (CONT=1):** the counter keeps running. The timeout interval is (PERIOD+1)*(PRE+1) cycles.
- **Timeout event:** rising edge of (count == 0), detected with a registered copy. It sets TO.
- **Period write:** PERIOD updates at the write edge. On the next edge:
  - count <= new PERIOD;
  - p <= 0;
  - RUN <= 0. Software must re-START the channel.

## Timing
- **Reset values:**
  - readdata = 0; irq = 0; irq_vec = 0.
  - All TO, RUN, CONTROL fields, p and SNAP = 0.
  - PERIOD and count = RESET_PERIOD.
  - The zero-detect register resets to 0, so RESET_PERIOD=0 raises TO one cycle after reset.
- **Read:** readdata reflects the addressed register as sampled at edge N and is valid after edge N. readdata updates every cycle regardless of chipselect.
- **Write:** registers update at the edge where chipselect & ~write_n.
- **START:** RUN=1 one cycle after the write. The first tick occurs PRE+1 cycles after RUN rises.
- **TO latency:** TO is visible in STATUS reads, and irq asserts, one cycle after count becomes 0.
- **Simultaneous events:**
  - A timeout event and a TO clear (STATUS write or global W1C) on the same edge: TO = 1, so no interrupt is lost.
  - A period write while count==0 and a tick is due: the reload of the new PERIOD wins, and RUN=0.
- **Wrap-around:**
  - The count never underflows; 0 always reloads.
  - PERIOD=0 in continuous mode with PRE=0: count stays 0, and TO is set only once per zero-entry (edge-detected).
- **Channel isolation:** channels are fully independent. Accesses to one channel never disturb another's count, p, or TO.
- **Reset mid-count:** everything returns to reset values asynchronously. irq deasserts immediately.

## Test plan
- **Reset defaults:** after reset, read word 2 -> 49999; read word 0 -> 0; irq = 0.
- **Prescaled continuous timing:** ch0 PERIOD=9, CONTROL=0x0307 (PRE=3, CONT, ITO, START) -> irq_vec[0] rises 40 cycles apart on every period. Write STATUS -> irq drops the next cycle, and reasserts at the next timeout.
- **One-shot:** ch1 PERIOD=4, PRE=0, CONTROL=0x5 -> TO set once, RUN=0 after 6 cycles, count holds at 4.
- **Global W1C and clear/event collision:** two channels pending; a global write of 0x2 clears ch1 only. A STATUS clear coincident with a timeout -> TO remains 1.
- **Period write:** write PERIOD while running -> RUN=0 the next cycle and count = new PERIOD. A snapshot write then returns the new PERIOD at +3.
- **Unmapped access and latency:** a write to word 29 has no effect. A read of word 29 -> 0. readdata updates exactly one cycle after the address is presented.

Source files
------------

// File: rtl/avalon_multi_timer_if.sv
`default_nettype none
// ============================================================================
// avalon_multi_timer_if : Avalon-MM slave bus plus interrupt lines of the timer
// Rev 1.0 - initial release
// ============================================================================
interface avalon_multi_timer_if #(
  parameter int NUM_CH = 2
);
  logic              chipselect;
  logic              write_n;
  logic [4:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  modport master (
    output chipselect, write_n, address, writedata,
    input  readdata, irq, irq_vec
  );

  modport slave (
    input  chipselect, write_n, address, writedata,
    output readdata, irq, irq_vec
  );
endinterface
`default_nettype wire

// File: rtl/avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// avalon_multi_timer : NUM_CH prescaled down-counters with snapshot and IRQs
// Rev 1.0 - initial release
// ============================================================================
module avalon_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  avalon_multi_timer_if.slave bus
);

  localparam logic [4:0] GLOBAL_ADDR = 5'd31;

  logic                     wr_en;
  logic                     wr_global;
  logic [NUM_CH-1:0]        to_vec;
  logic [NUM_CH-1:0]        ito_vec;
  logic [NUM_CH-1:0][31:0]  stat_rd;
  logic [NUM_CH-1:0][31:0]  ctrl_rd;
  logic [NUM_CH-1:0][31:0]  per_rd;
  logic [NUM_CH-1:0][31:0]  snap_rd;
  logic [31:0]              readdata_d;
  logic [31:0]              readdata_q;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_global = wr_en & (bus.address == GLOBAL_ADDR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic             wr_stat, wr_ctrl, wr_per, wr_snap;
    logic             to_q, to_d, run_q, run_d;
    logic             ito_q, ito_d, cont_q, cont_d;
    logic             zero_q, pw_q, pw_d;
    logic [7:0]       pre_q, pre_d, p_q, p_d;
    logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
    logic             tick, cnt_zero, to_evt, to_clr;

    assign sel      = wr_en & (bus.address[4:2] == 3'(c));
    assign wr_stat  = sel & (bus.address[1:0] == 2'd0);
    assign wr_ctrl  = sel & (bus.address[1:0] == 2'd1);
    assign wr_per   = sel & (bus.address[1:0] == 2'd2);
    assign wr_snap  = sel & (bus.address[1:0] == 2'd3);

    assign cnt_zero = (cnt_q == '0);
    assign tick     = run_q & (p_q == pre_q);
    assign to_evt   = cnt_zero & ~zero_q;
    assign to_clr   = wr_stat | (wr_global & bus.writedata[c]);

    always_comb begin
      // A timeout on the same edge as a clear must not be lost.
      to_d     = to_evt ? 1'b1 : (to_clr ? 1'b0 : to_q);
      ito_d    = wr_ctrl ? bus.writedata[0]    : ito_q;
      cont_d   = wr_ctrl ? bus.writedata[1]    : cont_q;
      pre_d    = wr_ctrl ? bus.writedata[15:8] : pre_q;
      period_d = wr_per  ? bus.writedata[CNT_W-1:0] : period_q;
      snap_d   = wr_snap ? cnt_q : snap_q;
      pw_d     = wr_per;
      cnt_d    = cnt_q;
      p_d      = p_q;
      run_d    = run_q;
      // The edge after a period write reloads and halts, overriding any tick.
      if (pw_q) begin
        cnt_d = period_q;
        p_d   = '0;
        run_d = 1'b0;
      end else begin
        if (tick) begin
          cnt_d = cnt_zero ? period_q : cnt_q - CNT_W'(1);
          p_d   = '0;
          if (cnt_zero & ~cont_q) run_d = 1'b0;
        end else if (run_q) begin
          p_d = p_q + 8'd1;
        end
        if (wr_ctrl & bus.writedata[2]) begin
          run_d = 1'b1;
        end else if (wr_ctrl & bus.writedata[3]) begin
          run_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        to_q     <= 1'b0;
        run_q    <= 1'b0;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        pre_q    <= '0;
        p_q      <= '0;
        period_q <= CNT_W'(RESET_PERIOD);
        cnt_q    <= CNT_W'(RESET_PERIOD);
        snap_q   <= '0;
        zero_q   <= 1'b0;
        pw_q     <= 1'b0;
      end else begin
        to_q     <= to_d;
        run_q    <= run_d;
        ito_q    <= ito_d;
        cont_q   <= cont_d;
        pre_q    <= pre_d;
        p_q      <= p_d;
        period_q <= period_d;
        cnt_q    <= cnt_d;
        snap_q   <= snap_d;
        zero_q   <= cnt_zero;
        pw_q     <= pw_d;
      end
    end

    assign to_vec[c]  = to_q;
    assign ito_vec[c] = ito_q;
    assign stat_rd[c] = {30'd0, run_q, to_q};
    assign ctrl_rd[c] = {16'd0, pre_q, 6'd0, cont_q, ito_q};
    assign per_rd[c]  = 32'(period_q);
    assign snap_rd[c] = 32'(snap_q);
  end

  always_comb begin
    readdata_d = '0;
    if (bus.address == GLOBAL_ADDR) begin
      readdata_d = 32'(to_vec);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.address[4:2] == 3'(c)) begin
          case (bus.address[1:0])
            2'd0:    readdata_d = stat_rd[c];
            2'd1:    readdata_d = ctrl_rd[c];
            2'd2:    readdata_d = per_rd[c];
            default: readdata_d = snap_rd[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq_vec  = to_vec & ito_vec;
  assign bus.irq      = |(to_vec & ito_vec);

endmodule
`default_nettype wire

// File: tb/tb_avalon_multi_timer.sv
`default_nettype none
// ============================================================================
// tb_avalon_multi_timer : register table plus timing sequences for the timer
// Rev 1.0 - initial release
// ============================================================================
module tb_avalon_multi_timer;
  localparam int NUM_CH = 2;
  localparam int NV     = 19;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  avalon_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  avalon_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(32), .RESET_PERIOD(49999)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.chk = ~wr; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(posedge clk); #1;
    d = bus.readdata;
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_vec(input int idx, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (bus.irq_vec[idx]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_irq_vec%0d: no rise within %0d cycles", idx, limit);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int t0, t1, t2, wc;

    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;

    tbl[0]  = mk(1'b0, 5'd2,  32'h0,        32'd49999,    "rst_period0");
    tbl[1]  = mk(1'b0, 5'd0,  32'h0,        32'h0,        "rst_status0");
    tbl[2]  = mk(1'b0, 5'd1,  32'h0,        32'h0,        "rst_ctrl0");
    tbl[3]  = mk(1'b0, 5'd3,  32'h0,        32'h0,        "rst_snap0");
    tbl[4]  = mk(1'b0, 5'd6,  32'h0,        32'd49999,    "rst_period1");
    tbl[5]  = mk(1'b0, 5'd31, 32'h0,        32'h0,        "rst_global");
    tbl[6]  = mk(1'b1, 5'd1,  32'h0000_AB0B, 32'h0,       "wr_ctrl0");
    tbl[7]  = mk(1'b0, 5'd1,  32'h0,        32'h0000_AB03, "ctrl0_readback");
    tbl[8]  = mk(1'b1, 5'd29, 32'hFFFF_FFFF, 32'h0,       "wr_w29");
    tbl[9]  = mk(1'b0, 5'd29, 32'h0,        32'h0,        "unmapped_w29");
    tbl[10] = mk(1'b1, 5'd8,  32'h0000_FFFF, 32'h0,       "wr_ch2");
    tbl[11] = mk(1'b0, 5'd8,  32'h0,        32'h0,        "unmapped_ch2");
    tbl[12] = mk(1'b0, 5'd28, 32'h0,        32'h0,        "unmapped_w28");
    tbl[13] = mk(1'b1, 5'd6,  32'h0001_2345, 32'h0,       "wr_period1");
    tbl[14] = mk(1'b0, 5'd6,  32'h0,        32'h0001_2345, "period1_readback");
    tbl[15] = mk(1'b1, 5'd7,  32'h0,        32'h0,        "wr_snap1");
    tbl[16] = mk(1'b0, 5'd7,  32'h0,        32'h0001_2345, "snap1_after_reload");
    tbl[17] = mk(1'b0, 5'd5,  32'h0,        32'h0,        "ctrl1_isolated");
    tbl[18] = mk(1'b0, 5'd2,  32'h0,        32'd49999,    "period0_isolated");

    repeat (2) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'd0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      bus.chipselect = 1'b1; bus.write_n = ~tbl[i].wr;
      bus.address = tbl[i].addr; bus.writedata = tbl[i].data;
      @(posedge clk); #1;
      if (tbl[i].chk) check(tbl[i].name, bus.readdata, tbl[i].exp);
      @(negedge clk);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

    // Prescaled continuous channel 0: 40-cycle interval, clear and collision.
    do_reset();
    bus_write(5'd2, 32'd9);
    @(negedge clk);
    bus_write(5'd1, 32'h0000_0307);
    wc = cyc;
    wait_vec(0, 200, t0);
    check("cont_first_to", 32'(t0 - wc), 32'd37);
    bus_write(5'd0, 32'h0);
    check("status_clear_irq", {31'd0, bus.irq}, 32'h0);
    wait_vec(0, 200, t1);
    check("cont_interval1", 32'(t1 - t0), 32'd40);
    bus_write(5'd0, 32'h0);
    wait_vec(0, 200, t2);
    check("cont_interval2", 32'(t2 - t1), 32'd40);
    bus_write(5'd0, 32'h0);
    check("irq_vec_cleared", 32'(bus.irq_vec), 32'h0);
    while (cyc < t2 + 39) @(negedge clk);
    bus_write(5'd0, 32'h0);
    check("clear_event_collision_irq", {31'd0, bus.irq}, 32'h1);
    bus_read(5'd0, rd);
    check("collision_status", rd, 32'h3);
    bus_write(5'd1, 32'h0000_0008);

    // One-shot channel 1, then global W1C with both channels pending.
    bus_write(5'd6, 32'd4);
    @(negedge clk);
    bus_write(5'd5, 32'h0000_0005);
    wc = cyc;
    wait_vec(1, 50, t0);
    check("oneshot_to_latency", 32'(t0 - wc), 32'd5);
    bus_read(5'd4, rd);
    check("oneshot_status", rd, 32'h1);
    repeat (10) @(negedge clk);
    bus_write(5'd7, 32'h0);
    bus_read(5'd7, rd);
    check("oneshot_count_holds", rd, 32'd4);
    bus_read(5'd31, rd);
    check("global_both_pending", rd, 32'h3);
    bus_write(5'd31, 32'h2);
    bus_read(5'd31, rd);
    check("global_w1c_ch1", rd, 32'h1);
    check("irq_after_w1c", {31'd0, bus.irq}, 32'h0);
    repeat (20) @(negedge clk);
    bus_read(5'd31, rd);
    check("oneshot_to_once", rd, 32'h1);

    // Period write while running halts the channel and reloads the count.
    bus_write(5'd31, 32'h1);
    bus_write(5'd2, 32'd100);
    @(negedge clk);
    bus_write(5'd1, 32'h0000_0007);
    repeat (10) @(negedge clk);
    bus_read(5'd0, rd);
    check("running_status", rd, 32'h2);
    bus_write(5'd2, 32'h55);
    @(negedge clk);
    bus_read(5'd0, rd);
    check("period_write_stops", rd, 32'h0);
    bus_write(5'd3, 32'h0);
    bus_read(5'd3, rd);
    check("snap_new_period", rd, 32'h55);

    // Read latency is one cycle and independent of chipselect.
    bus.chipselect = 1'b0; bus.address = 5'd29;
    @(negedge clk);
    bus.address = 5'd2;
    #1;
    check("latency_before_edge", bus.readdata, 32'h0);
    @(posedge clk); #1;
    check("latency_after_edge", bus.readdata, 32'h55);
    @(negedge clk);

    // Zero period raises TO; asynchronous reset drops irq immediately.
    bus_write(5'd2, 32'd0);
    @(negedge clk);
    bus_write(5'd1, 32'h0000_0001);
    repeat (3) @(negedge clk);
    check("zero_period_irq", {31'd0, bus.irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'd0, bus.irq}, 32'h0);
    check("async_reset_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(5'd2, rd);
    check("reset_period_restored", rd, 32'd49999);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
